// File: rtl/key_schedule_multi_pkg.sv
// Shared constants, state encoding and helpers for the multi-size AES key expansion.
// Holds the S-box table used by the SubWord lookups.
package key_schedule_multi_pkg;

  localparam int unsigned Nb    = 4;
  localparam int unsigned WordW = 32;

  localparam logic [1:0] Mode128 = 2'b00;
  localparam logic [1:0] Mode192 = 2'b01;
  localparam logic [1:0] Mode256 = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StGen
  } state_e;

  // Nk - 1 is the window tap holding w[i-Nk].
  function automatic logic [2:0] nk_m1(input logic [1:0] mode);
    unique case (mode)
      Mode192: nk_m1 = 3'd5;
      Mode256: nk_m1 = 3'd7;
      default: nk_m1 = 3'd3;
    endcase
  endfunction

  // Index of the final word, 4*Nr+3.
  function automatic logic [5:0] last_word(input logic [1:0] mode);
    unique case (mode)
      Mode192: last_word = 6'd51;
      Mode256: last_word = 6'd59;
      default: last_word = 6'd43;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  localparam logic [7:0] Sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/key_schedule_multi_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module key_schedule_multi_sub_word
  import key_schedule_multi_pkg::*;
(
  input  logic [WordW-1:0] word_i,
  output logic [WordW-1:0] word_o
);

  assign word_o = {Sbox[word_i[31:24]], Sbox[word_i[23:16]],
                   Sbox[word_i[15:8]],  Sbox[word_i[7:0]]};

endmodule

// File: rtl/key_schedule_multi.sv
// Word-serial AES-128/192/256 key expansion emitting one 128-bit round key every four cycles.
// A window of the last Nk words feeds the recurrence; a 4-word assembler builds round keys.
module key_schedule_multi
  import key_schedule_multi_pkg::*;
#(
  parameter bit EN_192 = 1'b1,
  parameter bit EN_256 = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic [255:0] key,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         w_e,
  output logic         en_o,
  output logic         busy
);

  state_e       state_q, state_d;
  logic [255:0] key_q, key_d;
  logic [2:0]   nk_m1_q, nk_m1_d;
  logic [5:0]   last_q, last_d;
  logic [5:0]   i_q, i_d;
  logic [2:0]   j_q, j_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [31:0]  win_q [8];
  logic [31:0]  win_d [8];
  logic [31:0]  asm_q [3];
  logic [31:0]  asm_d [3];
  logic [127:0] round_key_q, round_key_d;
  logic [3:0]   round_idx_q, round_idx_d;
  logic         w_e_q, w_e_d;
  logic         en_o_q, en_o_d;

  logic [1:0]   mode_eff;
  logic [31:0]  prev_w, old_w, sw_in, sw_out, new_word;
  logic         word_vld;

  // Disabled key sizes fall back to AES-128.
  always_comb begin
    mode_eff = Mode128;
    if (EN_192 && (mode == Mode192)) mode_eff = Mode192;
    if (EN_256 && (mode == Mode256)) mode_eff = Mode256;
  end

  assign prev_w = win_q[0];
  assign old_w  = win_q[nk_m1_q];
  assign sw_in  = (j_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  key_schedule_multi_sub_word u_sub_word (
    .word_i (sw_in),
    .word_o (sw_out)
  );

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    nk_m1_d     = nk_m1_q;
    last_d      = last_q;
    i_d         = i_q;
    j_d         = j_q;
    rcon_d      = rcon_q;
    win_d       = win_q;
    asm_d       = asm_q;
    round_key_d = round_key_q;
    round_idx_d = round_idx_q;
    w_e_d       = 1'b0;
    en_o_d      = 1'b0;
    new_word    = '0;
    word_vld    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The cycle carrying en_o still counts as busy, so en is not taken then.
        if (en && !en_o_q) begin
          key_d   = key;
          nk_m1_d = nk_m1(mode_eff);
          last_d  = last_word(mode_eff);
          i_d     = '0;
          j_d     = '0;
          rcon_d  = 8'h01;
          state_d = StLoad;
        end
      end
      StLoad: begin
        new_word = key_q[255:224];
        key_d    = key_q << 32;
        word_vld = 1'b1;
      end
      StGen: begin
        word_vld = 1'b1;
        if (j_q == 3'd0) begin
          new_word = old_w ^ sw_out ^ {rcon_q, 24'h0};
          rcon_d   = xtime(rcon_q);
        end else if ((nk_m1_q == 3'd7) && (j_q == 3'd4)) begin
          new_word = old_w ^ sw_out;
        end else begin
          new_word = old_w ^ prev_w;
        end
      end
      default: state_d = StIdle;
    endcase

    if (word_vld) begin
      i_d = i_q + 6'd1;
      j_d = (j_q == nk_m1_q) ? 3'd0 : j_q + 3'd1;
      if ((state_q == StLoad) && (j_q == nk_m1_q)) state_d = StGen;
      if (i_q == last_q) begin
        state_d = StIdle;
        en_o_d  = 1'b1;
      end

      win_d[0] = new_word;
      for (int k = 1; k < 8; k++) win_d[k] = win_q[k-1];

      unique case (i_q[1:0])
        2'd0: asm_d[0] = new_word;
        2'd1: asm_d[1] = new_word;
        2'd2: asm_d[2] = new_word;
        default: begin
          round_key_d = {asm_q[0], asm_q[1], asm_q[2], new_word};
          round_idx_d = i_q[5:2];
          w_e_d       = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      key_q       <= '0;
      nk_m1_q     <= 3'd3;
      last_q      <= 6'd43;
      i_q         <= '0;
      j_q         <= '0;
      rcon_q      <= 8'h01;
      for (int k = 0; k < 8; k++) win_q[k] <= '0;
      for (int k = 0; k < 3; k++) asm_q[k] <= '0;
      round_key_q <= '0;
      round_idx_q <= '0;
      w_e_q       <= 1'b0;
      en_o_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      nk_m1_q     <= nk_m1_d;
      last_q      <= last_d;
      i_q         <= i_d;
      j_q         <= j_d;
      rcon_q      <= rcon_d;
      win_q       <= win_d;
      asm_q       <= asm_d;
      round_key_q <= round_key_d;
      round_idx_q <= round_idx_d;
      w_e_q       <= w_e_d;
      en_o_q      <= en_o_d;
    end
  end

  assign round_key = round_key_q;
  assign round_idx = round_idx_q;
  assign w_e       = w_e_q;
  assign en_o      = en_o_q;
  assign busy      = (state_q != StIdle) || en_o_q;

endmodule

// File: tb/tb_key_schedule_multi.sv
// Directed bench for key_schedule_multi: known-answer round keys for all three key sizes,
// strobe timing, ignored requests while busy, and asynchronous reset mid-run.
module tb_key_schedule_multi;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [1:0]   mode;
  logic [255:0] key;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         w_e, en_o, busy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [127:0] got [15];
  int nwe, first_lat, done_lat, eno_cnt, post_we;
  logic idx_ok, busy_c1, busy_done, busy_after;

  localparam logic [127:0] K1   = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  key_schedule_multi dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .key       (key),
    .round_key (round_key),
    .round_idx (round_idx),
    .w_e       (w_e),
    .en_o      (en_o),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycle c=1 is the cycle right after the accepting edge; outputs sampled on negedges.
  task automatic run_req(input logic [1:0] m, input logic [255:0] k, input int inj_cyc,
                         input logic [255:0] inj_key, input int rst_cyc);
    nwe = 0; first_lat = 0; done_lat = 0; eno_cnt = 0; post_we = 0;
    idx_ok = 1'b1; busy_c1 = 1'b0; busy_done = 1'b0; busy_after = 1'b1;
    for (int r = 0; r < 15; r++) got[r] = '0;
    @(negedge clk);
    mode = m; key = k; en = 1'b1;
    @(negedge clk);
    en = 1'b0; mode = 2'b11; key = ~k;
    for (int c = 1; c <= 100; c++) begin
      if (c > 1) @(negedge clk);
      en = 1'b0;
      if (c == 1) busy_c1 = busy;
      if (w_e) begin
        if (first_lat == 0) first_lat = c;
        if (done_lat != 0) post_we++;
        else begin
          if (round_idx != nwe[3:0]) idx_ok = 1'b0;
          got[round_idx] = round_key;
          nwe++;
        end
      end
      if (en_o) begin
        eno_cnt++;
        if (done_lat == 0) begin
          done_lat = c;
          busy_done = busy;
        end
      end
      if ((done_lat != 0) && (c == done_lat + 1)) busy_after = busy;
      if (c == inj_cyc) begin
        en = 1'b1; key = inj_key; mode = 2'b10;
      end
      if (c == rst_cyc) begin
        #2 reset = 1'b1;
        #1;
        check("rst_round_key", round_key, '0);
        check("rst_outs", {123'd0, round_idx, w_e}, '0);
        check("rst_busy_eno", {126'd0, busy, en_o}, '0);
      end
      if (c == rst_cyc + 2) reset = 1'b0;
      if ((done_lat != 0) && (c >= done_lat + 8)) break;
    end
    en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'b00; key = '0;
    repeat (2) @(negedge clk);
    check("reset_round_key", round_key, '0);
    check("reset_outs", {121'd0, round_idx, w_e, en_o, busy}, '0);
    reset = 1'b0;

    // 1: AES-128 text key
    run_req(2'b00, {K1, 128'h0}, 0, '0, 0);
    check("s1_rk0", got[0], K1);
    check("s1_rk1", got[1], 128'he232fcf191129188b159e4e6d679a293);
    check("s1_rk10", got[10], 128'h28fddef86da4244accc0a4fe3b316f26);
    check("s1_nwe", 128'(nwe), 128'd11);
    check("s1_done_lat", 128'(done_lat), 128'd45);
    check("s1_eno_cnt", 128'(eno_cnt), 128'd1);
    check("s1_idx_seq", 128'(idx_ok), 128'd1);
    check("s1_busy", {125'd0, busy_c1, busy_done, busy_after}, {125'd0, 3'b110});

    // 2: FIPS-197 AES-128, with en raised in the en_o cycle (must be ignored)
    run_req(2'b00, {K2, 128'h0}, 45, {K1, 128'h0}, 0);
    check("s2_rk0", got[0], K2);
    check("s2_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("s2_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("s2_first_lat", 128'(first_lat), 128'd5);
    check("s2_post_we", 128'(post_we), 128'd0);
    check("s2_busy_after", 128'(busy_after), 128'd0);

    // 3: AES-192
    run_req(2'b01, {K192, 64'h0}, 0, '0, 0);
    check("s3_rk0", got[0], K192[191:64]);
    check("s3_rk1", got[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    check("s3_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);
    check("s3_nwe", 128'(nwe), 128'd13);
    check("s3_idx_seq", 128'(idx_ok), 128'd1);
    check("s3_done_lat", 128'(done_lat), 128'd53);

    // 4: AES-256
    run_req(2'b10, K256, 0, '0, 0);
    check("s4_rk0", got[0], K256[255:128]);
    check("s4_rk1", got[1], K256[127:0]);
    check("s4_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);
    check("s4_nwe", 128'(nwe), 128'd15);
    check("s4_done_lat", 128'(done_lat), 128'd61);

    // 5: mid-run request with another key and mode is dropped
    run_req(2'b00, {K1, 128'h0}, 20, K256, 0);
    check("s5_rk1", got[1], 128'he232fcf191129188b159e4e6d679a293);
    check("s5_rk10", got[10], 128'h28fddef86da4244accc0a4fe3b316f26);
    check("s5_nwe", 128'(nwe), 128'd11);
    check("s5_done_lat", 128'(done_lat), 128'd45);

    // 6: asynchronous reset just after rk3, then a clean FIPS-197 run
    run_req(2'b00, {K2, 128'h0}, 0, '0, 18);
    check("s6_rk3", got[3], 128'h3d80477d4716fe3e1e237e446d7a883b);
    check("s6_nwe", 128'(nwe), 128'd4);
    check("s6_eno_cnt", 128'(eno_cnt), 128'd0);
    run_req(2'b00, {K2, 128'h0}, 0, '0, 0);
    check("s6b_rk0", got[0], K2);
    check("s6b_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("s6b_first_lat", 128'(first_lat), 128'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
